// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and a return-address stack, drives a
// one-cycle synchronous instruction memory and hands words to the control unit.
module fetch_unit #(
   parameter int                ADDR_W      = 18,
   parameter int                DATA_W      = 32,
   parameter int                STACK_DEPTH = 8,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_en,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [1:0]        redirect_sel,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic              stack_overflow,
   output logic              stack_underflow
);

   localparam int PTR_W = $clog2(STACK_DEPTH);
   localparam int SP_W  = PTR_W + 1;

   localparam logic [1:0] SEL_JR   = 2'b00;
   localparam logic [1:0] SEL_JMP  = 2'b01;
   localparam logic [1:0] SEL_CALL = 2'b10;
   localparam logic [1:0] SEL_RET  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RESP,
      S_VALID
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] pc, pc_next;
   logic [SP_W-1:0]   sp, sp_next;
   logic              push_en;
   logic              ovf_set, unf_set;
   logic              handshake;
   logic              stack_full, stack_empty;
   logic [PTR_W-1:0]  top_idx;
   logic [ADDR_W-1:0] ret_addr;
   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

   assign imem_addr   = pc;
   assign handshake   = (state == S_VALID) && instr_ready;
   assign stack_full  = (sp == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   // Low pointer bits minus one wraps correctly even when sp == STACK_DEPTH.
   assign top_idx     = sp[PTR_W-1:0] - PTR_W'(1);
   assign ret_addr    = instr_pc + ADDR_W'(1);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking (<=) so every register samples
      // pre-edge values; combinational blocks below use blocking (=).
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned, which would infer a latch.
      state_next  = state;
      imem_en     = 1'b0;
      instr_valid = 1'b0;
      case (state)
         S_IDLE:  state_next = S_REQ;
         S_REQ: begin
            imem_en    = 1'b1;
            state_next = S_RESP;
         end
         S_RESP:  state_next = S_VALID;
         S_VALID: begin
            instr_valid = 1'b1;
            if (instr_ready) state_next = S_REQ;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- next-PC / stack control ----------------
   always_comb begin
      pc_next = pc;
      sp_next = sp;
      push_en = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (handshake) begin
         if (!redirect) begin
            pc_next = pc + ADDR_W'(1);
         end else begin
            case (redirect_sel)
               SEL_JR, SEL_JMP: pc_next = redirect_target;
               SEL_CALL: begin
                  pc_next = redirect_target;
                  if (stack_full) begin
                     ovf_set = 1'b1;
                  end else begin
                     push_en = 1'b1;
                     sp_next = sp + SP_W'(1);
                  end
               end
               SEL_RET: begin
                  if (stack_empty) begin
                     pc_next = RESET_PC;
                     unf_set = 1'b1;
                  end else begin
                     pc_next = stack_mem[top_idx];
                     sp_next = sp - SP_W'(1);
                  end
               end
               default: pc_next = pc;
            endcase
         end
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc              <= RESET_PC;
         sp              <= '0;
         instr           <= '0;
         instr_pc        <= RESET_PC;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
      end else begin
         pc <= pc_next;
         sp <= sp_next;
         if (state == S_RESP) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
         end
         if (ovf_set) stack_overflow  <= 1'b1;
         if (unf_set) stack_underflow <= 1'b1;
      end
   end

   // NOTE: stack storage has no reset; only sp is cleared, so entries above
   // sp are don't-care and the array maps onto plain RAM/flops without reset.
   always_ff @(posedge clk) begin
      if (push_en) stack_mem[sp[PTR_W-1:0]] <= ret_addr;
   end

endmodule
